// File: rtl/async_sram_ctrl_pkg.sv
// Shared types for the asynchronous SRAM controller: FSM state encoding and wait counter width.
// The TURN state exists only when ASYNC_SRAM_CTRL_TURNAROUND_EN is defined.
package async_sram_ctrl_pkg;

  localparam int CNT_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RESP
`ifdef ASYNC_SRAM_CTRL_TURNAROUND_EN
    ,
    TURN
`endif
  } state_e;

endpackage

// File: rtl/async_sram_wait_cnt.sv
// Strobe-width down counter: load a start value, count down to zero and stop there.
module async_sram_wait_cnt
  import async_sram_ctrl_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load,
  input  logic [CNT_WIDTH-1:0] i_loadVal,
  input  logic                 i_dec,
  output logic                 o_zero
);

  logic [CNT_WIDTH-1:0] r_count;

  // Load wins over decrement; the count saturates at zero instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/async_sram_ctrl.sv
// Request/response front end for an asynchronous SRAM with a SETUP / STROBE / HOLD access sequence.
// Optional macro ASYNC_SRAM_CTRL_TURNAROUND_EN adds a one-cycle TURN state after every read completion.
module async_sram_ctrl
  import async_sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  sram_cs_o,
  output logic                  sram_we_o,
  output logic                  sram_oe_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_data_o,
  output logic                  sram_data_oe_o,
  input  logic [DATA_WIDTH-1:0] sram_data_i
);

  localparam logic [CNT_WIDTH-1:0] LP_LOAD = CNT_WIDTH'(WAIT_CYCLES - 1);

  state_e                r_state;
  logic                  r_isWrite;
  logic                  r_reqReady;
  logic                  r_rspValid;
  logic [DATA_WIDTH-1:0] r_rspRdata;
  logic                  r_cs;
  logic                  r_we;
  logic                  r_oe;
  logic                  r_dataOe;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic w_cntLoad;
  logic w_cntDec;
  logic w_cntZero;

  // Counter is loaded while leaving SETUP, so it holds WAIT_CYCLES-1 in the first STROBE cycle.
  assign w_cntLoad = (r_state == SETUP);
  assign w_cntDec  = (r_state == STROBE);

  async_sram_wait_cnt u_waitCnt (
    .i_clk     (clk_i),
    .i_rst     (rst_i),
    .i_load    (w_cntLoad),
    .i_loadVal (LP_LOAD),
    .i_dec     (w_cntDec),
    .o_zero    (w_cntZero)
  );

  // All outputs are registered and change together with the state they belong to.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_isWrite  <= 1'b0;
      r_reqReady <= 1'b1;
      r_rspValid <= 1'b0;
      r_rspRdata <= '0;
      r_cs       <= 1'b0;
      r_we       <= 1'b0;
      r_oe       <= 1'b0;
      r_dataOe   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid_i) begin
            r_state    <= SETUP;
            r_reqReady <= 1'b0;
            r_isWrite  <= req_we_i;
            r_addr     <= req_addr_i;
            r_dataOe   <= req_we_i;
            if (req_we_i) begin
              r_wdata <= req_wdata_i;
            end
          end
        end
        SETUP: begin
          r_state <= STROBE;
          r_cs    <= 1'b1;
          r_we    <= r_isWrite;
          r_oe    <= !r_isWrite;
        end
        STROBE: begin
          if (w_cntZero) begin
            r_cs <= 1'b0;
            r_we <= 1'b0;
            r_oe <= 1'b0;
            if (r_isWrite) begin
              r_state <= HOLD;
            end else begin
              r_rspRdata <= sram_data_i;
              r_rspValid <= 1'b1;
              r_state    <= RESP;
            end
          end
        end
        HOLD: begin
          r_dataOe   <= 1'b0;
          r_reqReady <= 1'b1;
          r_state    <= IDLE;
        end
        RESP: begin
          if (rsp_ready_i) begin
            r_rspValid <= 1'b0;
`ifdef ASYNC_SRAM_CTRL_TURNAROUND_EN
            r_state    <= TURN;
`else
            r_reqReady <= 1'b1;
            r_state    <= IDLE;
`endif
          end
        end
`ifdef ASYNC_SRAM_CTRL_TURNAROUND_EN
        TURN: begin
          r_reqReady <= 1'b1;
          r_state    <= IDLE;
        end
`endif
        default: begin
          r_reqReady <= 1'b1;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_o    = r_reqReady;
  assign rsp_valid_o    = r_rspValid;
  assign rsp_rdata_o    = r_rspRdata;
  assign sram_cs_o      = r_cs;
  assign sram_we_o      = r_we;
  assign sram_oe_o      = r_oe;
  assign sram_addr_o    = r_addr;
  assign sram_data_o    = r_wdata;
  assign sram_data_oe_o = r_dataOe;

endmodule

// File: tb/tb_async_sram_ctrl.sv
// Testbench for async_sram_ctrl: three instances (WAIT_CYCLES 2, 1, 15) each with a behavioural SRAM;
// expected turnaround gap follows ASYNC_SRAM_CTRL_TURNAROUND_EN.
module tb_async_sram_ctrl;

  localparam int NI = 3;
  localparam int W0 = 2;
`ifdef ASYNC_SRAM_CTRL_TURNAROUND_EN
  localparam int TURN_GAP = 1;
`else
  localparam int TURN_GAP = 0;
`endif

  logic clk = 1'b0;
  logic rst;

  logic [NI-1:0] reqValid, reqReady, reqWe, rspValid, rspReady;
  logic [NI-1:0] sramCs, sramWe, sramOe, sramDataOe;
  logic [7:0]    reqAddr  [NI];
  logic [7:0]    reqWdata [NI];
  logic [7:0]    rspRdata [NI];
  logic [7:0]    sramAddr [NI];
  logic [7:0]    sramDout [NI];
  logic [7:0]    sramDin  [NI];

  int tests = 0;
  int fails = 0;
  int violations = 0;
  logic [7:0] refMem [256];

  typedef struct {
    bit         we;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] expData;
    bit         hold;
  } vec_t;

  always #5 clk = ~clk;

  // One controller per strobe width, each with its own behavioural SRAM.
  for (genvar g = 0; g < NI; g++) begin : gInst
    logic [7:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    async_sram_ctrl #(
      .ADDR_WIDTH  (8),
      .DATA_WIDTH  (8),
      .WAIT_CYCLES (g == 0 ? 2 : (g == 1 ? 1 : 15))
    ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .req_valid_i    (reqValid[g]),
      .req_ready_o    (reqReady[g]),
      .req_we_i       (reqWe[g]),
      .req_addr_i     (reqAddr[g]),
      .req_wdata_i    (reqWdata[g]),
      .rsp_valid_o    (rspValid[g]),
      .rsp_ready_i    (rspReady[g]),
      .rsp_rdata_o    (rspRdata[g]),
      .sram_cs_o      (sramCs[g]),
      .sram_we_o      (sramWe[g]),
      .sram_oe_o      (sramOe[g]),
      .sram_addr_o    (sramAddr[g]),
      .sram_data_o    (sramDout[g]),
      .sram_data_oe_o (sramDataOe[g]),
      .sram_data_i    (sramDin[g])
    );

    always @(negedge clk) begin
      if (sramCs[g] && sramWe[g] && sramDataOe[g]) mem[sramAddr[g]] = sramDout[g];
    end

    assign sramDin[g] = (sramCs[g] && sramOe[g]) ? mem[sramAddr[g]] : 8'h00;
  end

  // Bus-contention monitor: write and read enables, or read enable and data drive, must never coincide.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if ((sramWe[k] && sramOe[k]) || (sramOe[k] && sramDataOe[k])) violations++;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one request on instance k starting at a negedge and measures the access from the accept edge.
  task automatic applyStimulus(input int k, input bit isWe, input logic [7:0] addr,
                               input logic [7:0] data, input logic [7:0] expData, input bit holdResp,
                               output logic [7:0] rdata, output int lat, output int csWidth,
                               output int csStart, output int doeWidth, output int waitCyc);
    int n;
    bit addrOk;
    rdata = '0; lat = -1; csWidth = 0; csStart = -1; doeWidth = 0; waitCyc = 0; addrOk = 1'b1;
    while (!reqReady[k] && waitCyc < 50) begin
      @(negedge clk);
      waitCyc++;
    end
    if (!reqReady[k]) begin
      checkOutput("readyTimeout", 32'd0, 32'd1);
      return;
    end
    reqValid[k] = 1'b1; reqWe[k] = isWe; reqAddr[k] = addr; reqWdata[k] = data;
    @(negedge clk);
    reqValid[k] = 1'b0;
    n = 1;
    while (lat < 0 && n < 64) begin
      if (sramCs[k]) begin
        csWidth++;
        if (csStart < 0) csStart = n;
      end
      if (sramDataOe[k]) doeWidth++;
      if (sramAddr[k] !== addr) addrOk = 1'b0;
      if (isWe ? reqReady[k] : rspValid[k]) lat = n - 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput("addrStable", 32'(addrOk), 32'd1);
    if (lat < 0) begin
      checkOutput("completionTimeout", 32'd0, 32'd1);
      return;
    end
    if (!isWe) begin
      rdata = rspRdata[k];
      if (holdResp) begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          checkOutput("rspHeldValid", 32'(rspValid[k]), 32'd1);
          checkOutput("rspHeldData", 32'(rspRdata[k]), 32'(expData));
          checkOutput("noAcceptInResp", 32'(reqReady[k]), 32'd0);
        end
      end
      rspReady[k] = 1'b1;
      @(negedge clk);
      rspReady[k] = 1'b0;
      checkOutput("rspDropped", 32'(rspValid[k]), 32'd0);
    end
  endtask

  // Transaction on the WAIT_CYCLES=2 instance, checked against the reference memory and timing rules.
  task automatic txn0(input bit isWe, input logic [7:0] addr, input logic [7:0] data,
                      input logic [7:0] expData, input bit holdResp, input string tag,
                      output int waitCyc);
    logic [7:0] rdata;
    int lat, csWidth, csStart, doeWidth;
    applyStimulus(0, isWe, addr, data, expData, holdResp, rdata, lat, csWidth, csStart, doeWidth,
                  waitCyc);
    checkOutput({tag, ".csWidth"}, 32'(csWidth), 32'(W0));
    checkOutput({tag, ".setupLen"}, 32'(csStart), 32'd2);
    if (isWe) begin
      refMem[addr] = data;
      checkOutput({tag, ".wrOccupancy"}, 32'(lat), 32'(W0 + 2));
      checkOutput({tag, ".dataOeWidth"}, 32'(doeWidth), 32'(W0 + 2));
      checkOutput({tag, ".memModel"}, 32'(gInst[0].mem[addr]), 32'(data));
    end else begin
      checkOutput({tag, ".rdLatency"}, 32'(lat), 32'(W0 + 1));
      checkOutput({tag, ".dataOeWidth"}, 32'(doeWidth), 32'd0);
      checkOutput({tag, ".rdData"}, 32'(rdata), 32'(expData));
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".reqReady"}, 32'(reqReady), 32'({NI{1'b1}}));
    checkOutput({tag, ".rspValid"}, 32'(rspValid), 32'd0);
    checkOutput({tag, ".rspRdata"}, 32'(rspRdata[0]), 32'd0);
    checkOutput({tag, ".cs"}, 32'(sramCs), 32'd0);
    checkOutput({tag, ".we"}, 32'(sramWe), 32'd0);
    checkOutput({tag, ".oe"}, 32'(sramOe), 32'd0);
    checkOutput({tag, ".dataOe"}, 32'(sramDataOe), 32'd0);
    checkOutput({tag, ".addr"}, 32'(sramAddr[0]), 32'd0);
    checkOutput({tag, ".dout"}, 32'(sramDout[0]), 32'd0);
  endtask

  initial begin
    vec_t vecs [8];
    int waitCyc, lat, csWidth, csStart, doeWidth;
    logic [7:0] rdata, a, d;
    bit isWe, sawValid;

    vecs[0] = '{1'b1, 8'h3C, 8'hA5, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 8'h3C, 8'h00, 8'hA5, 1'b1};
    vecs[2] = '{1'b1, 8'h00, 8'h5A, 8'h00, 1'b0};
    vecs[3] = '{1'b1, 8'hFF, 8'hC3, 8'h00, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 8'h00, 8'h5A, 1'b0};
    vecs[5] = '{1'b0, 8'hFF, 8'h00, 8'hC3, 1'b0};
    vecs[6] = '{1'b1, 8'h3C, 8'h0F, 8'h00, 1'b0};
    vecs[7] = '{1'b0, 8'h3C, 8'h00, 8'h0F, 1'b0};

    for (int i = 0; i < 256; i++) refMem[i] = 8'h00;
    reqValid = '0; reqWe = '0; rspReady = '0;
    for (int k = 0; k < NI; k++) begin
      reqAddr[k] = '0; reqWdata[k] = '0;
    end

    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkResetState("inReset");
    rst = 1'b0;
    @(negedge clk);
    checkResetState("afterReset");

    for (int i = 0; i < 8; i++) begin
      txn0(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].expData, vecs[i].hold,
           $sformatf("vec%0d", i), waitCyc);
    end

    // Read immediately followed by a write: the write may only start after the turnaround gap.
    txn0(1'b0, 8'h3C, 8'h00, refMem[8'h3C], 1'b0, "turnRd", waitCyc);
    txn0(1'b1, 8'h3D, 8'h66, 8'h00, 1'b0, "turnWr", waitCyc);
    checkOutput("turnGap", 32'(waitCyc), 32'(TURN_GAP));

    for (int i = 0; i < 30; i++) begin
      isWe = 1'($urandom_range(0, 1));
      a = 8'h40 + 8'($urandom_range(0, 7));
      d = 8'($urandom);
      txn0(isWe, a, d, refMem[a], 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i), waitCyc);
    end

    // Reset in the second STROBE cycle of a read aborts it without a response.
    waitCyc = 0;
    while (!reqReady[0] && waitCyc < 50) begin
      @(negedge clk);
      waitCyc++;
    end
    reqValid[0] = 1'b1; reqWe[0] = 1'b0; reqAddr[0] = 8'h3C;
    @(negedge clk);
    reqValid[0] = 1'b0;
    @(negedge clk);
    checkOutput("abort.strobeOn", 32'(sramOe[0] & sramCs[0]), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort.csLow", 32'(sramCs[0]), 32'd0);
    checkOutput("abort.oeLow", 32'(sramOe[0]), 32'd0);
    checkOutput("abort.noRsp", 32'(rspValid[0]), 32'd0);
    rst = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rspValid[0] || sramCs[0]) sawValid = 1'b1;
    end
    checkOutput("abort.quietAfter", 32'(sawValid), 32'd0);
    checkOutput("abort.readyAfter", 32'(reqReady[0]), 32'd1);

    // Strobe width extremes on the WAIT_CYCLES=1 and 15 instances.
    for (int k = 1; k < NI; k++) begin
      int wc;
      wc = (k == 1) ? 1 : 15;
      applyStimulus(k, 1'b1, 8'h10, 8'h77, 8'h00, 1'b0, rdata, lat, csWidth, csStart, doeWidth,
                    waitCyc);
      checkOutput($sformatf("w%0d.wrCsWidth", wc), 32'(csWidth), 32'(wc));
      checkOutput($sformatf("w%0d.wrOccupancy", wc), 32'(lat), 32'(wc + 2));
      applyStimulus(k, 1'b0, 8'h10, 8'h00, 8'h77, 1'b0, rdata, lat, csWidth, csStart, doeWidth,
                    waitCyc);
      checkOutput($sformatf("w%0d.rdCsWidth", wc), 32'(csWidth), 32'(wc));
      checkOutput($sformatf("w%0d.rdLatency", wc), 32'(lat), 32'(wc + 1));
      checkOutput($sformatf("w%0d.rdData", wc), 32'(rdata), 32'h77);
    end

    repeat (3) @(negedge clk);
    checkOutput("busExclusive", 32'(violations), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
